// File: rtl/snooper_pkg.sv
// Shared trace types for the snooper trace path.
// TRACE_CAPTURE_TSTAMP_EN adds a 64-bit timestamp to each buffered entry.
package snooper_pkg;

  localparam int unsigned TSTAMP_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } trace_t;

  typedef struct packed {
    trace_t              trace;
`ifdef TRACE_CAPTURE_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;
`endif
  } trace_entry_t;

endpackage

// File: rtl/trace_buf_ctrl.sv
// FIFO bookkeeping for trace_capture_buffer: pointers, fill count and the
// push/pop/drop decision. Storage lives in the parent.
module trace_buf_ctrl #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_req_i,
  input  logic                     out_ready_i,
  output logic                     push_o,
  output logic                     pop_o,
  output logic                     drop_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH)-1:0] wr_ptr_o,
  output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic [$clog2(DEPTH):0]   fill_d_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          full, pop_raw;

  assign full    = (fill_q == FW'(DEPTH));
  assign valid_o = (fill_q != '0);
  assign pop_raw = valid_o & out_ready_i;

  // clear_i wins over everything; a trace offered during clear is neither stored nor dropped.
  assign pop_o  = pop_raw & ~clear_i;
  assign push_o = push_req_i & (~full | pop_raw) & ~clear_i;
  assign drop_o = push_req_i & full & ~pop_raw & ~clear_i;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    fill_d = fill_q;
    if (clear_i) begin
      wr_d   = '0;
      rd_d   = '0;
      fill_d = '0;
    end else begin
      if (push_o) wr_d = wr_q + AW'(1);
      if (pop_o)  rd_d = rd_q + AW'(1);
      unique case ({push_o, pop_o})
        2'b10:   fill_d = fill_q + FW'(1);
        2'b01:   fill_d = fill_q - FW'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
    end
  end

  assign wr_ptr_o = wr_q;
  assign rd_ptr_o = rd_q;
  assign fill_o   = fill_q;
  assign fill_d_o = fill_d;

endmodule

// File: rtl/trace_capture_buffer.sv
// Buffers filter-accepted retire traces for the trace writer, counting overflow drops.
// TRACE_CAPTURE_TSTAMP_EN stamps each entry with a free-running 64-bit cycle count.
module trace_capture_buffer
  import snooper_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WATERMARK = 12,
  parameter int unsigned DROP_W    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   capture_en_i,
  input  logic                   trace_valid_i,
  input  trace_t                 traces_i,
  input  logic                   filter_en_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output trace_entry_t           out_entry_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   wm_o,
  output logic [DROP_W-1:0]      drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam logic [FW-1:0] WmLevel = FW'(WATERMARK);

  logic          push_req, push, pop, drop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic          wm_q;
  trace_entry_t  mem_q [DEPTH];
  trace_entry_t  wr_entry;

  assign push_req = trace_valid_i & filter_en_i & capture_en_i;

  trace_buf_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .push_req_i (push_req),
    .out_ready_i(out_ready_i),
    .push_o     (push),
    .pop_o      (pop),
    .drop_o     (drop),
    .valid_o    (out_valid_o),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .fill_o     (fill_o),
    .fill_d_o   (fill_d)
  );

`ifdef TRACE_CAPTURE_TSTAMP_EN
  logic [TSTAMP_W-1:0] tstamp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tstamp_q <= '0;
    end else if (clear_i) begin
      tstamp_q <= '0;
    end else begin
      tstamp_q <= tstamp_q + TSTAMP_W'(1);
    end
  end

  always_comb begin
    wr_entry.trace  = traces_i;
    wr_entry.tstamp = tstamp_q;
  end
`else
  always_comb begin
    wr_entry.trace = traces_i;
  end
`endif

  // Storage needs no reset: the head is only meaningful while out_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr] <= wr_entry;
  end

  assign out_entry_o = mem_q[rd_ptr];

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
      wm_q       <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      wm_q       <= (fill_d >= WmLevel);
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign wm_o       = wm_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed self-checking bench for trace_capture_buffer (main DEPTH=16 instance plus a
// small DROP_W=3 instance for saturation). Timestamp checks build with TRACE_CAPTURE_TSTAMP_EN.
module tb_trace_capture_buffer;
  import snooper_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear, cap_en, tvalid, fen, ready;
  trace_t       tr;
  logic         ovalid;
  trace_entry_t oentry;
  logic [4:0]   fill;
  logic         wm;
  logic [31:0]  drop;

  logic         tvalid2, ready2;
  trace_t       tr2;
  logic         ovalid2;
  trace_entry_t oentry2;
  logic [1:0]   fill2;
  logic         wm2;
  logic [2:0]   drop2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trace_capture_buffer #(
    .DEPTH(16), .WATERMARK(12), .DROP_W(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .capture_en_i(cap_en),
    .trace_valid_i(tvalid), .traces_i(tr), .filter_en_i(fen),
    .out_valid_o(ovalid), .out_ready_i(ready), .out_entry_o(oentry),
    .fill_o(fill), .wm_o(wm), .drop_cnt_o(drop)
  );

  trace_capture_buffer #(
    .DEPTH(2), .WATERMARK(2), .DROP_W(3)
  ) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .capture_en_i(cap_en),
    .trace_valid_i(tvalid2), .traces_i(tr2), .filter_en_i(1'b1),
    .out_valid_o(ovalid2), .out_ready_i(ready2), .out_entry_o(oentry2),
    .fill_o(fill2), .wm_o(wm2), .drop_cnt_o(drop2)
  );

  function automatic trace_t mk(input int i);
    trace_t t;
    t.pc   = 32'h1000 + 32'(i);
    t.insn = ~(32'h1000 + 32'(i));
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tvalid = 1'b0; fen = 1'b0; ready = 1'b0; clear = 1'b0;
    tr = '0; tvalid2 = 1'b0; ready2 = 1'b0; tr2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    cap_en = 1'b1;
    rst_n  = 1'b0;
    #1;
    total++; if (fill !== 5'd0 || ovalid !== 1'b0 || drop !== 32'd0 || wm !== 1'b0) begin
      bad++; $display("FAIL reset_state fill=%0d valid=%b drop=%0d wm=%b want 0", fill, ovalid, drop, wm);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      tvalid = 1'b1; fen = 1'b1; tr = mk(i);
      step();
    end
    tvalid = 1'b0;
    total++; if (fill !== 5'd5) begin
      bad++; $display("FAIL reset_prefill fill=%0d want 5", fill);
    end
    rst_n = 1'b0;
    #1;
    total++; if (fill !== 5'd0 || ovalid !== 1'b0 || drop !== 32'd0) begin
      bad++; $display("FAIL reset_midfill fill=%0d valid=%b drop=%0d want 0", fill, ovalid, drop);
    end
    step();
    rst_n = 1'b1;
    step();
    total++; if (ovalid !== 1'b0 || fill !== 5'd0) begin
      bad++; $display("FAIL reset_release valid=%b fill=%0d want 0", ovalid, fill);
    end
  endtask

  task automatic test_filter();
    int outs = 0;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tvalid = 1'b1; fen = (i % 2 == 0); tr = mk(i);
      step();
      if (i % 2 == 0) begin
        total++; if (ovalid !== 1'b1 || oentry.trace !== mk(i)) begin
          bad++; $display("FAIL filter_out[%0d] valid=%b pc=%h want 1 pc=%h", i, ovalid,
                          oentry.trace.pc, mk(i).pc);
        end
        if (ovalid === 1'b1) outs++;
      end else begin
        total++; if (ovalid !== 1'b0) begin
          bad++; $display("FAIL filter_gap[%0d] valid=%b want 0", i, ovalid);
        end
      end
    end
    tvalid = 1'b0; fen = 1'b0;
    total++; if (outs !== 4) begin
      bad++; $display("FAIL filter_count got=%0d want 4", outs);
    end
    ready = 1'b0;
  endtask

  task automatic test_overflow();
    int exp_fill, exp_drop;
    ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tvalid = 1'b1; fen = 1'b1; tr = mk(k - 1);
      step();
      exp_fill = (k > 16) ? 16 : k;
      exp_drop = (k > 16) ? k - 16 : 0;
      total++; if (fill !== 5'(exp_fill) || drop !== 32'(exp_drop) ||
                   wm !== (exp_fill >= 12)) begin
        bad++; $display("FAIL overflow[%0d] fill=%0d drop=%0d wm=%b want %0d %0d %b", k, fill,
                        drop, wm, exp_fill, exp_drop, exp_fill >= 12);
      end
    end
    tvalid = 1'b0;
    total++; if (oentry.trace !== mk(0)) begin
      bad++; $display("FAIL overflow_head pc=%h want %h", oentry.trace.pc, mk(0).pc);
    end
  endtask

  task automatic test_full_push_pop();
    int exp_idx;
    tvalid = 1'b1; fen = 1'b1; tr = mk(20); ready = 1'b1;
    step();
    tvalid = 1'b0; ready = 1'b0;
    total++; if (fill !== 5'd16 || drop !== 32'd4 || oentry.trace !== mk(1)) begin
      bad++; $display("FAIL full_push_pop fill=%0d drop=%0d pc=%h want 16 4 %h", fill, drop,
                      oentry.trace.pc, mk(1).pc);
    end
    ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp_idx = (j < 15) ? j + 1 : 20;
      total++; if (ovalid !== 1'b1 || oentry.trace !== mk(exp_idx)) begin
        bad++; $display("FAIL drain[%0d] valid=%b pc=%h want 1 %h", j, ovalid,
                        oentry.trace.pc, mk(exp_idx).pc);
      end
      step();
    end
    ready = 1'b0;
    total++; if (fill !== 5'd0 || ovalid !== 1'b0 || wm !== 1'b0) begin
      bad++; $display("FAIL drain_empty fill=%0d valid=%b wm=%b want 0", fill, ovalid, wm);
    end
  endtask

  task automatic test_clear();
    clear = 1'b1; step(); clear = 1'b0;
    for (int k = 0; k < 19; k++) begin
      tvalid = 1'b1; fen = 1'b1; tr = mk(40 + k);
      step();
    end
    tvalid = 1'b0; ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    ready = 1'b0;
    total++; if (fill !== 5'd10 || drop !== 32'd3) begin
      bad++; $display("FAIL clear_setup fill=%0d drop=%0d want 10 3", fill, drop);
    end
    clear = 1'b1; tvalid = 1'b1; fen = 1'b1; tr = mk(99); ready = 1'b1;
    step();
    clear = 1'b0; tvalid = 1'b0;
    total++; if (fill !== 5'd0 || drop !== 32'd0 || wm !== 1'b0 || ovalid !== 1'b0) begin
      bad++; $display("FAIL clear_prio fill=%0d drop=%0d wm=%b valid=%b want 0", fill, drop, wm,
                      ovalid);
    end
    step();
    total++; if (fill !== 5'd0 || ovalid !== 1'b0) begin
      bad++; $display("FAIL clear_after fill=%0d valid=%b want 0", fill, ovalid);
    end
    ready = 1'b0;
  endtask

  task automatic test_capture_en();
    for (int k = 0; k < 2; k++) begin
      tvalid = 1'b1; fen = 1'b1; tr = mk(60 + k);
      step();
    end
    cap_en = 1'b0; ready = 1'b1; tr = mk(70);
    step();
    total++; if (fill !== 5'd1 || oentry.trace !== mk(61)) begin
      bad++; $display("FAIL capen_drain1 fill=%0d pc=%h want 1 %h", fill, oentry.trace.pc,
                      mk(61).pc);
    end
    step();
    total++; if (fill !== 5'd0 || ovalid !== 1'b0 || drop !== 32'd0) begin
      bad++; $display("FAIL capen_drain2 fill=%0d valid=%b drop=%0d want 0", fill, ovalid, drop);
    end
    tvalid = 1'b0; fen = 1'b0; ready = 1'b0; cap_en = 1'b1;
  endtask

  task automatic test_saturation();
    int exp_drop;
    ready2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tvalid2 = 1'b1; tr2 = mk(80 + k);
      step();
      exp_drop = (k <= 2) ? 0 : ((k - 2 > 7) ? 7 : k - 2);
      total++; if (drop2 !== 3'(exp_drop) || fill2 !== ((k >= 2) ? 2'd2 : 2'd1)) begin
        bad++; $display("FAIL saturate[%0d] drop=%0d fill=%0d want %0d", k, drop2, fill2,
                        exp_drop);
      end
    end
    tvalid2 = 1'b0;
  endtask

`ifdef TRACE_CAPTURE_TSTAMP_EN
  task automatic test_tstamp();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) step();
    tvalid = 1'b1; fen = 1'b1; tr = mk(100);
    step();
    tvalid = 1'b0;
    step(); step();
    tvalid = 1'b1; tr = mk(103);
    step();
    tvalid = 1'b0;
    total++; if (oentry.tstamp !== 64'd100) begin
      bad++; $display("FAIL tstamp_first got=%0d want 100", oentry.tstamp);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    total++; if (oentry.tstamp !== 64'd103 || oentry.trace !== mk(103)) begin
      bad++; $display("FAIL tstamp_second got=%0d want 103", oentry.tstamp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_clear();
    test_capture_en();
    test_saturation();
`ifdef TRACE_CAPTURE_TSTAMP_EN
    test_tstamp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
